// File: rtl/logit_packer_pkg.sv
// Shared definitions for logit_packer: class-count default, index width,
// pad value and FSM state encoding.
package logit_packer_pkg;

    localparam int unsigned NUM_CLASSES_DEF = 24;
    localparam int unsigned CLS_IDX_W       = 5;
    localparam int unsigned PAD_MAX_W       = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    // All-ones filler for empty score slots; callers cast to their width.
    function automatic logic [PAD_MAX_W-1:0] pad_value();
        return '1;
    endfunction

endpackage

// File: rtl/logit_packer.sv
// logit_packer: gathers NUM_CLASSES streamed class scores into one packed
// frame and presents it for a single cycle.
// Optional feature: define LOGIT_PACKER_ERRCNT_EN to count dropped/aborted
// frame events on err_cnt (saturating); otherwise err_cnt is tied to zero.
module logit_packer
    import logit_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEF
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [DATA_WIDTH-1:0]             s_data,
    input  logic                              s_valid,
    input  logic                              s_first,
    output logic                              s_ready,
    output logic [NUM_CLASSES*DATA_WIDTH-1:0] m_data,
    output logic                              m_valid,
    output logic                              busy,
    output logic [7:0]                        err_cnt
);

    localparam int unsigned CNT_W     = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int unsigned FRAME_W   = NUM_CLASSES * DATA_WIDTH;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_CLASSES - 1);
    localparam logic [DATA_WIDTH-1:0] PAD  = DATA_WIDTH'(pad_value());

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic [DATA_WIDTH-1:0]  slots      [NUM_CLASSES];
    logic [DATA_WIDTH-1:0]  slots_next [NUM_CLASSES];
    logic [FRAME_W-1:0]     frame_next;
    logic                   load_out;
    logic                   accept;

    // Ready is withheld during reset and for the single emit cycle.
    assign s_ready = resetn && (state != ST_EMIT);
    assign busy    = (state != ST_IDLE);
    assign accept  = s_valid && s_ready;

    // Next-state, slot counter and working-buffer update.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        slots_next = slots;
        load_out   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && s_first) begin
                    slots_next[0] = s_data;
                    cnt_next      = CNT_W'(1);
                    state_next    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    if (s_first) begin
                        slots_next    = '{default: PAD};
                        slots_next[0] = s_data;
                        cnt_next      = CNT_W'(1);
                    end else begin
                        slots_next[cnt] = s_data;
                        if (cnt == LAST_SLOT) begin
                            cnt_next   = '0;
                            state_next = ST_EMIT;
                            load_out   = 1'b1;
                        end else begin
                            cnt_next = cnt + CNT_W'(1);
                        end
                    end
                end
            end
            ST_EMIT: begin
                slots_next = '{default: PAD};
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
            default: begin
                slots_next = '{default: PAD};
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Pack the post-write buffer so the final beat lands in the output frame.
    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_pack
        assign frame_next[g*DATA_WIDTH +: DATA_WIDTH] = slots_next[g];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counter, working buffer and output frame registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt     <= '0;
            slots   <= '{default: PAD};
            m_data  <= '1;
            m_valid <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            slots   <= slots_next;
            m_valid <= load_out;
            if (load_out) begin
                m_data <= frame_next;
            end
        end
    end

`ifdef LOGIT_PACKER_ERRCNT_EN
    logic       err_evt;
    logic [7:0] err_q;

    // Stray beat while idle, or a new frame start cutting a partial frame.
    always_comb begin
        err_evt = accept && (((state == ST_IDLE) && !s_first) ||
                             ((state == ST_FILL) &&  s_first));
    end

    // Saturating error event counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_q <= 8'h00;
        end else if (err_evt && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_logit_packer.sv
// Self-checking bench for logit_packer using a frame scoreboard.
`timescale 1ns/1ps
module tb_logit_packer;

    localparam int unsigned DW = 16;
    localparam int unsigned NC = 24;
    localparam int unsigned FW = DW * NC;
`ifdef LOGIT_PACKER_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk;
    logic          resetn;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_first;
    logic          s_ready;
    logic [FW-1:0] m_data;
    logic          m_valid;
    logic          busy;
    logic [7:0]    err_cnt;

    logit_packer #(
        .DATA_WIDTH (DW),
        .NUM_CLASSES(NC)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .s_data (s_data),
        .s_valid(s_valid),
        .s_first(s_first),
        .s_ready(s_ready),
        .m_data (m_data),
        .m_valid(m_valid),
        .busy   (busy),
        .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] data;
        time           t;
    } exp_t;

    exp_t          sb [$];
    time           pulses [$];
    int unsigned   tests = 0;
    int unsigned   fails = 0;
    bit            m_in;
    int            m_slot;
    logic [FW-1:0] m_buf;
    int            exp_err;
    logic [FW-1:0] last_frame;

    task automatic check_eq(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] exp_err_val();
        return ERR_EN ? FW'(exp_err) : '0;
    endfunction

    task automatic err_inc();
        if (exp_err < 255) exp_err++;
    endtask

    // Reference behaviour of one accepted beat.
    task automatic model_accept(input logic [DW-1:0] d, input logic f);
        if (f) begin
            if (m_in) err_inc();
            m_buf         = '1;
            m_buf[DW-1:0] = d;
            m_slot        = 1;
            m_in          = 1'b1;
        end else if (!m_in) begin
            err_inc();
        end else begin
            m_buf[m_slot*DW +: DW] = d;
            m_slot++;
            if (m_slot == NC) begin
                sb.push_back('{data: m_buf, t: $time});
                last_frame = m_buf;
                m_in       = 1'b0;
            end
        end
    endtask

    // Drive one beat and hold it until accepted (bounded wait).
    task automatic send(input logic [DW-1:0] d, input logic f);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_first = f;
        @(negedge clk);
        while (!s_ready && n < 8) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready) begin
            check_eq("ready_timeout", FW'(s_ready), FW'(1));
            return;
        end
        @(posedge clk);
        model_accept(d, f);
        #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_first = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        s_valid = 1'b0;
        s_first = 1'b0;
        resetn  = 1'b0;
        @(negedge clk);
        check_eq("sready_in_reset", FW'(s_ready), FW'(0));
        repeat (n) @(posedge clk);
        #1;
        resetn     = 1'b1;
        m_in       = 1'b0;
        m_slot     = 0;
        exp_err    = 0;
        last_frame = '1;
        check_eq("rst_mdata", m_data, '1);
        check_eq("rst_mvalid", FW'(m_valid), FW'(0));
        check_eq("rst_busy", FW'(busy), FW'(0));
        check_eq("rst_errcnt", FW'(err_cnt), FW'(0));
    endtask

    task automatic full_frame(input logic [DW-1:0] base);
        for (int k = 0; k < NC; k++) send(base + DW'(k), k == 0);
    endtask

    // Output monitor: every pulse must match the oldest expected frame.
    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (m_valid) begin
            check_eq("mvalid_expected", FW'(sb.size() != 0), FW'(1));
            check_eq("sready_in_emit", FW'(s_ready), FW'(0));
            check_eq("busy_in_emit", FW'(busy), FW'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("frame_data", m_data, e.data);
                check_eq("emit_time", FW'($time - 1), FW'(e.t));
                pulses.push_back($time);
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        logic [FW-1:0] ref_frame;
        int            np;
        resetn  = 1'b0;
        s_valid = 1'b0;
        s_first = 1'b0;
        s_data  = '0;
        m_in    = 1'b0;
        m_buf   = '1;
        exp_err = 0;
        do_reset(3);

        // Counting frame: slot k carries k+1.
        full_frame(DW'(1));
        idle(4);
        for (int k = 0; k < NC; k++) ref_frame[k*DW +: DW] = DW'(k + 1);
        check_eq("count_frame", m_data, ref_frame);
        check_eq("mdata_hold", m_data, last_frame);
        check_eq("idle_busy", FW'(busy), FW'(0));

        // Two back-to-back frames with s_valid held high.
        pulses.delete();
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < NC; k++) send(DW'($urandom), k == 0);
        idle(3);
        check_eq("b2b_pulses", FW'(pulses.size()), FW'(2));
        if (pulses.size() == 2) check_eq("b2b_gap", FW'(pulses[1] - pulses[0]), FW'(250));

        // Partial frame aborted by a new first beat.
        np = pulses.size();
        for (int k = 0; k < 10; k++) send(DW'($urandom), k == 0);
        full_frame(DW'(16'h0100));
        idle(3);
        check_eq("abort_pulses", FW'(pulses.size() - np), FW'(1));
        check_eq("abort_errcnt", FW'(err_cnt), exp_err_val());
        check_eq("abort_errcnt_abs", FW'(err_cnt), FW'(ERR_EN ? 1 : 0));

        // Stray beats while idle are dropped.
        for (int k = 0; k < 3; k++) begin
            send(DW'($urandom), 1'b0);
            check_eq("stray_busy", FW'(busy), FW'(0));
        end
        idle(1);
        check_eq("stray_errcnt", FW'(err_cnt), exp_err_val());
        full_frame(DW'(16'h2000));
        idle(3);

        // Reset in the middle of a frame.
        np = pulses.size();
        for (int k = 0; k < 12; k++) send(DW'($urandom), k == 0);
        do_reset(1);
        idle(3);
        check_eq("midrst_pulses", FW'(pulses.size() - np), FW'(0));
        check_eq("midrst_mdata", m_data, '1);
        full_frame(DW'(16'hA000));
        idle(3);
        check_eq("postrst_pulses", FW'(pulses.size() - np), FW'(1));

        // Error counter saturation.
        for (int k = 0; k < 301; k++) send(DW'($urandom), 1'b1);
        idle(1);
        check_eq("sat_errcnt", FW'(err_cnt), FW'(ERR_EN ? 8'hFF : 8'h00));
        check_eq("sat_errcnt_model", FW'(err_cnt), exp_err_val());
        full_frame(DW'(16'h5500));
        idle(3);

        check_eq("pending_frames", FW'(sb.size()), FW'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/logit_packer.md
LOGIT_PACKER -- requirements
Module: logit_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the width of one class score.
REQ-002 Parameter NUM_CLASSES, default 24, SHALL set the number of scores per frame.
REQ-003 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 resetn  input  1  SHALL be the reset, synchronous and active-low.
REQ-005 s_data  input  DATA_WIDTH  SHALL carry one class score per beat.
REQ-006 s_valid  input  1  SHALL qualify s_data.
REQ-007 s_first  input  1  SHALL mark the first score of a frame (class 0).
REQ-008 s_ready  output  1  SHALL indicate the block accepts a beat this cycle.
REQ-009 m_data  output  NUM_CLASSES*DATA_WIDTH  SHALL carry the packed frame; class k sits at bits [DATA_WIDTH*k +: DATA_WIDTH].
REQ-010 m_valid  output  1  SHALL be a one-cycle pulse marking m_data valid; there is no back-pressure.
REQ-011 busy  output  1  SHALL be high whenever the FSM is not IDLE.
REQ-012 err_cnt  output  8  SHALL report aborted/dropped frame events (see Configuration).

Function
REQ-013 A beat SHALL be accepted when s_valid && s_ready at a rising edge.
REQ-014 The FSM SHALL have states IDLE, FILL and EMIT.
REQ-015 In IDLE, s_ready SHALL be 1; an accepted beat with s_first=1 SHALL write slot 0, set the slot counter to 1 and move to FILL.
REQ-016 In IDLE, an accepted beat with s_first=0 SHALL be dropped and counted as an error; the state SHALL remain IDLE.
REQ-017 In FILL, s_ready SHALL be 1; an accepted beat with s_first=0 SHALL write the slot given by the counter and increment the counter.
REQ-018 In FILL, an accepted beat with s_first=1 SHALL abort the partial frame, count one error and restart at slot 0 (counter := 1) with no m_valid.
REQ-019 Acceptance of slot NUM_CLASSES-1 at edge N SHALL move the FSM to EMIT.
REQ-020 EMIT SHALL last exactly one cycle (N+1), with m_valid=1, s_ready=0 and the complete frame on m_data; the FSM then returns to IDLE.
REQ-021 m_data SHALL be a register loaded only when entering EMIT and held stable until the next EMIT.
REQ-022 The working buffer SHALL be refilled to all-ones (DATA_WIDTH{1'b1} per slot) on entering IDLE or on an abort, so no stale score leaks into a frame.
REQ-023 The slot counter width SHALL be $clog2(NUM_CLASSES); it SHALL never exceed NUM_CLASSES-1.
REQ-024 Scores SHALL pass through unmodified; the block performs no arithmetic on s_data.
REQ-025 Minimum frame period SHALL be NUM_CLASSES+1 cycles (one dead cycle for EMIT).

Reset
REQ-026 When resetn=0 at an edge: FSM:=IDLE, counter:=0, m_valid:=0, m_data:=all-ones, buffer:=all-ones, err_cnt:=0; s_ready SHALL be 0 while resetn=0.
REQ-027 Reset mid-FILL SHALL discard the partial frame silently (no m_valid, no error count).

Configuration
REQ-028 With macro LOGIT_PACKER_ERRCNT_EN defined, err_cnt SHALL increment by 1 per REQ-016/REQ-018 event and saturate at 8'hFF.
REQ-029 Without LOGIT_PACKER_ERRCNT_EN, err_cnt SHALL be tied to 8'h00 and no counter logic SHALL be synthesized; all other behaviour is identical.

Structure
REQ-030 A shared package SHALL hold the NUM_CLASSES default (24), the class-index width (5), the all-ones pad value function and the FSM state enum.
REQ-031 The block SHALL be a single module; no sub-module is required.

Verification
REQ-032 Reset, then 24 beats with s_data=k+1 (k=0..23), s_first on the first beat, back-to-back -> m_valid for exactly one cycle, 1 cycle after the last accept; slot k = k+1; s_ready=0 in that cycle.
REQ-033 Two back-to-back frames with s_valid held high -> exactly one stall cycle between them; two m_valid pulses, 25 cycles apart.
REQ-034 Send 10 beats, then s_first=1 with a new 24-beat frame -> single m_valid carrying only the new frame; err_cnt=1 (0 without the macro).
REQ-035 Send 3 beats with s_first=0 while IDLE -> no state change, busy=0, err_cnt=3; a following valid frame is packed correctly.
REQ-036 Assert resetn=0 for 1 cycle after 12 beats -> m_valid never pulses, m_data=all-ones, err_cnt=0; the next full frame emits normally.
REQ-037 Force 300 abort events with the macro defined -> err_cnt saturates at 8'hFF.
